csa_accum_ctrl: RTL and testbench

- Sequencer that reduces a variable-length stream of GRP_WIDTH-bit addend terms into one carry-save pair (sum, carry), using a single shared 3:2 compressor group.
- Each accepted term is folded into the registered (S, C) accumulator.
- Per-term two's-complement "+1" corrections are injected through the compressor's csign carry-in slot.
- Sits between the FMA partial-product/alignment stage and the final carry-propagate adder. It time-multiplexes one compressor row instead of building a full tree.

---
 rtl/csa_accum_ctrl_pkg.sv | 28 ++
 rtl/csa_accum_ctrl_compressor.sv | 40 ++++
 rtl/csa_accum_ctrl.sv | 163 ++++++++++++++++
 tb/tb_csa_accum_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_accum_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// csa_accum_ctrl_pkg
//
// Shared definitions for the FMA carry-save accumulation slice.
//   - Default datapath width of one compressor group.
//   - Default maximum number of terms folded per operation.
//   - Default width of the term counter (must satisfy 2**CNT_W > MAX_TERMS).
//   - Encoding of the accumulation controller state.
// -----------------------------------------------------------------------------
package csa_accum_ctrl_pkg;

    // Width of one addend term, of the accumulator and of the result pair.
    localparam int GRP_WIDTH_DEF = 79;

    // Terms folded before an operation is forcibly terminated.
    localparam int MAX_TERMS_DEF = 16;

    // Counter width; 2**CNT_W_DEF must exceed MAX_TERMS_DEF so the count
    // can represent MAX_TERMS itself.
    localparam int CNT_W_DEF = 5;

    // Controller state. ACC folds incoming terms, DONE presents the result.
    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } acc_state_t;

endpackage : csa_accum_ctrl_pkg

// File: rtl/csa_accum_ctrl_compressor.sv
// -----------------------------------------------------------------------------
// compressor3_2_group
//
// One row of WIDTH full adders used as a 3:2 carry-save compressor.
// Purely combinational. The carry word comes out already shifted left by
// one position: the carry out of the MSB is discarded (arithmetic is modulo
// 2**WIDTH) and bit 0 of the carry word is the csign carry-in slot.
//
// Ports:
//   in1, in2, in3 : WIDTH-bit operands
//   csign         : carry-in injected at bit 0 of the carry word
//   s             : WIDTH-bit sum word
//   cout          : WIDTH-bit shifted carry word
// -----------------------------------------------------------------------------
module compressor3_2_group
    import csa_accum_ctrl_pkg::*;
#(
    parameter int WIDTH = GRP_WIDTH_DEF
) (
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic             csign,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] cout
);

    // Majority of the lower WIDTH-1 bit positions only: the majority of the
    // top position would be shifted out of the group and never used.
    logic [WIDTH-2:0] maj;

    assign s   = in1 ^ in2 ^ in3;
    assign maj = (in1[WIDTH-2:0] & in2[WIDTH-2:0])
               | (in1[WIDTH-2:0] & in3[WIDTH-2:0])
               | (in2[WIDTH-2:0] & in3[WIDTH-2:0]);

    // Carries move up one weight; the free bit-0 slot carries csign.
    assign cout = {maj, csign};

endmodule : compressor3_2_group

// File: rtl/csa_accum_ctrl.sv
// -----------------------------------------------------------------------------
// csa_accum_ctrl
//
// Folds a variable-length stream of addend terms into one carry-save pair
// (S, C) using a single shared 3:2 compressor row. Each accepted term is
// compressed together with the registered S and C; a negated term arrives
// already bitwise-inverted and its two's-complement +1 is injected through
// the compressor csign slot. At all times S + C equals the sum of the terms
// accepted so far (with the +1 corrections), modulo 2**GRP_WIDTH.
//
// An operation ends on an accepted term flagged in_last, or when the
// MAX_TERMS-th term is accepted (out_ovf is then set unless that term also
// carried in_last). The pair is then held on the outputs until out_ready,
// after which the accumulator is cleared and a new operation may start in
// the following cycle.
//
// Ports:
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset, discards all partial state
//   in_valid   : a term is presented on in_data/in_neg/in_last
//   in_ready   : controller accepts a term this cycle (state ACC)
//   in_data    : addend term, already inverted if negated
//   in_neg     : term is negated; adds +1 via csign
//   in_last    : final term of the current operation
//   out_valid  : result pair valid (state DONE)
//   out_ready  : downstream takes the result
//   out_sum    : carry-save sum word
//   out_carry  : carry-save carry word, already shifted
//   out_terms  : number of terms folded into the result
//   out_ovf    : operation was cut off at MAX_TERMS without in_last
// -----------------------------------------------------------------------------
module csa_accum_ctrl
    import csa_accum_ctrl_pkg::*;
#(
    parameter int GRP_WIDTH = GRP_WIDTH_DEF,
    parameter int MAX_TERMS = MAX_TERMS_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [GRP_WIDTH-1:0] in_data,
    input  logic                 in_neg,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [GRP_WIDTH-1:0] out_sum,
    output logic [GRP_WIDTH-1:0] out_carry,
    output logic [CNT_W-1:0]     out_terms,
    output logic                 out_ovf
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

    acc_state_t state;
    acc_state_t state_next;

    logic [GRP_WIDTH-1:0] s_reg;
    logic [GRP_WIDTH-1:0] c_reg;
    logic [GRP_WIDTH-1:0] s_fold;
    logic [GRP_WIDTH-1:0] c_fold;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     count_inc;
    logic                 ovf;

    logic accept;     // a term is folded this cycle
    logic hit_max;    // the accepted term is term number MAX_TERMS
    logic finish;     // the accepted term closes the operation
    logic take;       // downstream consumes the result this cycle

    // -------------------------------------------------------------------------
    // Shared compressor row: the only arithmetic in the block.
    // -------------------------------------------------------------------------
    compressor3_2_group #(
        .WIDTH (GRP_WIDTH)
    ) u_csa (
        .in1   (s_reg),
        .in2   (c_reg),
        .in3   (in_data),
        .csign (in_neg),
        .s     (s_fold),
        .cout  (c_fold)
    );

    // Handshake qualifiers. Both depend only on registered state plus the
    // partner's valid/ready, so there is no combinational loop through the
    // handshake.
    assign accept    = in_valid  && (state == ST_ACC);
    assign take      = out_ready && (state == ST_DONE);
    assign count_inc = count + 1'b1;
    assign hit_max   = (count_inc == MAX_CNT);
    assign finish    = accept && (in_last || hit_max);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is assigned with non-blocking (<=) so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_ACC;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: the default assignment at the top of every always_comb keeps each
    // path fully specified, so no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_ACC:  if (finish) state_next = ST_DONE;
            ST_DONE: if (take)   state_next = ST_ACC;
            default:             state_next = ST_ACC;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            ST_ACC:  in_ready  = 1'b1;
            ST_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Accumulator, counter and overflow flag
    // -------------------------------------------------------------------------
    // NOTE: every datapath register is reset and cleared explicitly; these
    // are plain flops (not a memory array), so clearing them costs nothing
    // and the outputs read a defined 0 between operations.
    always_ff @(posedge clk) begin
        if (rst || take) begin
            s_reg <= '0;
            c_reg <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (accept) begin
            s_reg <= s_fold;
            c_reg <= c_fold;
            count <= count_inc;
            // Only a term that reaches MAX_TERMS without in_last overflows;
            // earlier accepts write 0, which is the cleared value anyway.
            ovf   <= hit_max && !in_last;
        end
    end

    // Outputs come straight from registers.
    assign out_sum   = s_reg;
    assign out_carry = c_reg;
    assign out_terms = count;
    assign out_ovf   = ovf;

endmodule : csa_accum_ctrl

// File: tb/tb_csa_accum_ctrl.sv
// -----------------------------------------------------------------------------
// tb_csa_accum_ctrl
//
// Self-checking bench for csa_accum_ctrl: a table of short operations with
// known results, hand-written sequences for the handshake, overflow and
// reset corner cases, and randomized operations checked against a
// plain-arithmetic reference (running sum of terms plus +1 per negation).
// -----------------------------------------------------------------------------
module tb_csa_accum_ctrl;

    localparam int W     = 79;
    localparam int MAXT  = 16;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_neg;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic [W-1:0]  out_carry;
    logic [CW-1:0] out_terms;
    logic          out_ovf;

    int n_vec = 0;
    int n_err = 0;

    csa_accum_ctrl #(
        .GRP_WIDTH (W),
        .MAX_TERMS (MAXT),
        .CNT_W     (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_neg    (in_neg),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_terms (out_terms),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    // Watchdog: the bench must never hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: advance past the next rising edge, then settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] pair_total();
        return out_sum + out_carry;
    endfunction

    // Present one term and hold it until accepted (bounded).
    task automatic send_term(input logic [W-1:0] d, input logic ng,
                             input logic lst);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_neg   = ng;
        in_last  = lst;
        while (!in_ready && guard < 20) begin
            step();
            guard++;
        end
        check("in_ready_before_accept", in_ready, 1);
        step();
        in_valid = 1'b0;
        in_neg   = 1'b0;
        in_last  = 1'b0;
    endtask

    // Consume the result after `hold` cycles of out_ready=0 and confirm the
    // return to an empty ACC state.
    task automatic release_result(input int hold);
        logic [W-1:0]  s0;
        logic [W-1:0]  c0;
        logic [CW-1:0] t0;
        s0 = out_sum;
        c0 = out_carry;
        t0 = out_terms;
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            step();
            check("held_out_valid", out_valid, 1);
            check("held_sum_stable", out_sum == s0 && out_carry == c0 &&
                  out_terms == t0, 1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("after_take_in_ready", in_ready, 1);
        check("after_take_out_valid", out_valid, 0);
        check("after_take_cleared", {out_sum, out_carry, out_terms, out_ovf}, 0);
    endtask

    // ------------------------------------------------------------------
    // Table of short operations with hand-derived results
    // ------------------------------------------------------------------
    typedef struct {
        string                 name;
        int                    n;
        logic [3:0][W-1:0]     data;
        logic [3:0]            neg;
        logic [W-1:0]          exp_total;
        logic                  exact;
        logic [W-1:0]          exp_sum;
        logic [W-1:0]          exp_carry;
        int                    exp_terms;
    } op_vec_t;

    op_vec_t tbl[4];

    // Reference model state for randomized operations.
    logic [W-1:0] m_total;
    int           m_count;

    initial begin
        logic [W-1:0] three;
        logic [W-1:0] ones;
        logic [W-1:0] s_hold;
        logic [W-1:0] d;
        logic         ng;
        int           len;
        int           nsend;
        logic         lst;
        logic         exp_ovf;

        three = W'(3);
        ones  = '1;

        // 5 + 7 + 9: S=1, C=20 from the bitwise XOR / majority rules.
        tbl[0] = '{name: "t5_7_9", n: 3, data: '0, neg: 4'b0000,
                   exp_total: W'(21), exact: 1'b1, exp_sum: W'(1),
                   exp_carry: W'(20), exp_terms: 3};
        tbl[0].data[0] = W'(5);
        tbl[0].data[1] = W'(7);
        tbl[0].data[2] = W'(9);
        // 10 - 3 with the negation presented as ~3 plus csign.
        tbl[1] = '{name: "t10_m3", n: 2, data: '0, neg: 4'b0010,
                   exp_total: W'(7), exact: 1'b0, exp_sum: '0,
                   exp_carry: '0, exp_terms: 2};
        tbl[1].data[0] = W'(10);
        tbl[1].data[1] = ~three;
        // Single negated term: S=data, C=1.
        tbl[2] = '{name: "t_single_neg", n: 1, data: '0, neg: 4'b0001,
                   exp_total: W'('h1235), exact: 1'b1, exp_sum: W'('h1234),
                   exp_carry: W'(1), exp_terms: 1};
        tbl[2].data[0] = W'('h1234);
        // All-ones + 2 wraps modulo 2**W to 1.
        tbl[3] = '{name: "t_wrap", n: 2, data: '0, neg: 4'b0000,
                   exp_total: W'(1), exact: 1'b0, exp_sum: '0,
                   exp_carry: '0, exp_terms: 2};
        tbl[3].data[0] = ones;
        tbl[3].data[1] = W'(2);

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_neg    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;

        // ---- reset state ----
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_outputs", {out_sum, out_carry, out_terms, out_ovf}, 0);
        step();
        check("idle_holds", {in_ready, out_valid, pair_total()}, {2'b10, W'(0)});

        // ---- table-driven operations ----
        for (int v = 0; v < 4; v++) begin
            for (int k = 0; k < tbl[v].n; k++) begin
                send_term(tbl[v].data[k], tbl[v].neg[k], k == tbl[v].n - 1);
                if (k != tbl[v].n - 1)
                    check({tbl[v].name, "_mid_out_valid"}, out_valid, 0);
            end
            check({tbl[v].name, "_out_valid"}, out_valid, 1);
            check({tbl[v].name, "_in_ready"}, in_ready, 0);
            check({tbl[v].name, "_total"}, pair_total(), tbl[v].exp_total);
            check({tbl[v].name, "_terms"}, out_terms, tbl[v].exp_terms);
            check({tbl[v].name, "_ovf"}, out_ovf, 0);
            if (tbl[v].exact) begin
                check({tbl[v].name, "_sum"}, out_sum, tbl[v].exp_sum);
                check({tbl[v].name, "_carry"}, out_carry, tbl[v].exp_carry);
            end
            release_result(v);
        end

        // ---- backpressure: in_valid held while DONE is stalled ----
        send_term(W'(11), 1'b0, 1'b1);
        s_hold = out_sum;
        in_valid = 1'b1;
        in_data  = W'('hFF);
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_in_ready", in_ready, 0);
            check("stall_stable", {out_valid, out_terms}, {1'b1, CW'(1)});
            check("stall_sum", out_sum, s_hold);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        check("stall_release_ready", {in_ready, out_valid, out_terms}, {2'b10, CW'(0)});
        send_term(W'(3), 1'b0, 1'b1);
        check("post_stall_total", pair_total(), W'(3));
        check("post_stall_terms", out_terms, 1);
        release_result(0);

        // ---- MAX_TERMS without and with in_last on the last term ----
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 1; i <= MAXT; i++) begin
                send_term(W'(1), 1'b0, (pass == 1) && (i == MAXT));
                if (i < MAXT) check("max_mid_out_valid", out_valid, 0);
            end
            check("max_out_valid", out_valid, 1);
            check("max_total", pair_total(), W'(MAXT));
            check("max_terms", out_terms, MAXT);
            check(pass == 0 ? "max_ovf_set" : "max_ovf_clear", out_ovf, pass == 0);
            release_result(1);
        end

        // ---- reset mid-operation ----
        send_term(W'(4), 1'b0, 1'b0);
        send_term(W'(4), 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_state", {in_ready, out_valid}, 2'b10);
        check("rst_mid_cleared", {out_sum, out_carry, out_terms, out_ovf}, 0);
        send_term(W'(4), 1'b0, 1'b1);
        check("rst_mid_total", pair_total(), W'(4));
        check("rst_mid_terms", out_terms, 1);

        // ---- reset while a result is pending ----
        check("rst_done_pending", out_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_done_dropped", {in_ready, out_valid, out_terms}, {2'b10, CW'(0)});

        // ---- randomized operations vs arithmetic reference ----
        for (int op = 0; op < 40; op++) begin
            len     = $urandom_range(1, 20);
            nsend   = (len > MAXT) ? MAXT : len;
            m_total = '0;
            m_count = 0;
            for (int k = 1; k <= nsend; k++) begin
                repeat ($urandom_range(0, 2)) begin
                    step();
                    check("rnd_idle_hold", pair_total(), m_total);
                end
                d   = W'({$urandom(), $urandom(), $urandom()});
                ng  = 1'($urandom_range(0, 1));
                lst = (k == len);
                send_term(d, ng, lst);
                m_total = m_total + d + W'(ng);
                m_count++;
                check("rnd_running_total", pair_total(), m_total);
                check("rnd_running_terms", out_terms, m_count);
                check("rnd_out_valid", out_valid, k == nsend);
            end
            exp_ovf = (len > MAXT);
            check("rnd_ovf", out_ovf, exp_ovf);
            release_result($urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_csa_accum_ctrl
